mem_access_ctrl: RTL and testbench
==================================

MEM_ACCESS_CTRL -- requirements
Module: mem_access_ctrl

Interface
REQ-001 Parameter: TIMEOUT_CYCLES, default 255, bus-wait limit in cycles (8-bit range, 1..255).
REQ-002 Port: clock  input  1  single system clock; all state changes on its rising edge.
REQ-003 Port: reset  input  1  synchronous, active-high reset.
REQ-004 Port: MemRead  input  1  from control unit; current instruction is a load (LW).
REQ-005 Port: MemWrite  input  1  from control unit; current instruction is a store (SW).
REQ-006 Port: ALU_result  input  32  byte address from the execute unit.
REQ-007 Port: write_data  input  32  store data, taken from the rt read-port data.
REQ-008 Port: read_data  output  32  load data returned to decode/writeback, registered.
REQ-009 Port: stall  output  1  freezes PC and register writes while an access is in flight.
REQ-010 Port: misalign  output  1  one-cycle pulse: access rejected because ALU_result[1:0] != 0.
REQ-011 Port: bus_req  output  1  bus request, held until bus_ack.
REQ-012 Port: bus_we  output  1  1 = write cycle, 0 = read cycle.
REQ-013 Port: bus_addr  output  32  word address: {ALU_result[31:2],2'b00}, registered.
REQ-014 Port: bus_wdata  output  32  registered store data.
REQ-015 Port: bus_rdata  input  32  read data, valid only in the bus_ack cycle.
REQ-016 Port: bus_ack  input  1  one-cycle completion strobe from the memory or I/O slave.
REQ-017 Port: bus_err  output  1  sticky timeout flag; present only with MEM_TIMEOUT_EN.

Function
REQ-018 FSM states: IDLE, REQ, DONE.
REQ-019 IDLE, MemRead|MemWrite=1, aligned:
  - latch address, write data and bus_we (MemWrite has priority if both are high);
  - go to REQ;
  - stall=1 combinationally in this same cycle.
REQ-020 IDLE, MemRead|MemWrite=1, ALU_result[1:0]!=0:
  - misalign=1 for one cycle;
  - no bus cycle; stay IDLE; stall=0; read_data unchanged.
REQ-021 REQ: bus_req=1, with bus_addr, bus_we and bus_wdata held stable until bus_ack.
REQ-022 REQ and bus_ack=1:
  - read: read_data<=bus_rdata;
  - drop bus_req next cycle; go to DONE.
REQ-023 DONE: stall=0 and bus_req=0 for exactly one cycle, then IDLE; a new request is not accepted in DONE.
REQ-024 stall=1 in every REQ cycle; latency = 1 + (bus_ack wait) + 1 cycles from request to next IDLE.
REQ-025 A bus_ack seen in IDLE or DONE is ignored.
REQ-026 A write cycle never modifies read_data.

Reset
REQ-027 reset=1 at any clock edge forces IDLE, including mid-REQ; any pending access is abandoned.
REQ-028 Reset values: read_data=0, bus_req=0, bus_we=0, bus_addr=0, bus_wdata=0, stall=0, misalign=0, bus_err=0, timeout counter=0.

Configuration
REQ-029 Macro MEM_TIMEOUT_EN defined:
  - an 8-bit counter increments each REQ cycle without bus_ack;
  - when the count reaches TIMEOUT_CYCLES, go to DONE, set read_data=32'hDEADBEEF on a read, set bus_err=1;
  - bus_err clears only on reset.
REQ-030 Macro MEM_TIMEOUT_EN undefined: no counter and no bus_err port; REQ waits indefinitely for bus_ack.

Verification
REQ-031 LW, ALU_result=0x10, bus_rdata=0x12345678, ack after 3 REQ cycles -> bus_addr=0x10, bus_we=0, stall high 4 cycles, read_data=0x12345678 in DONE.
REQ-032 SW, ALU_result=0x24, write_data=0xA5A5A5A5, ack on 1st REQ cycle -> bus_we=1, bus_wdata=0xA5A5A5A5, read_data unchanged, back in IDLE 2 cycles after acceptance.
REQ-033 LW, ALU_result=0x13 -> misalign pulse of 1 cycle, bus_req stays 0, stall 0.
REQ-034 reset asserted during 2nd REQ cycle -> next cycle IDLE, bus_req=0, stall=0, read_data=0; a later ack is ignored.
REQ-035 MEM_TIMEOUT_EN defined, TIMEOUT_CYCLES=4, LW with no ack -> DONE after 4 REQ cycles, read_data=0xDEADBEEF, bus_err=1 held until reset.
REQ-036 MemRead=MemWrite=1, ALU_result=0x8 -> treated as a write (bus_we=1).

Source files
------------

// File: rtl/mem_access_ctrl.sv
// Data-memory access controller: turns LW/SW from the pipeline into a stalled bus transaction.
// Optional bus-wait timeout with sticky bus_err is built when MEM_TIMEOUT_EN is defined.
module mem_access_ctrl #(
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        MemRead,
    input  logic        MemWrite,
    input  logic [31:0] ALU_result,
    input  logic [31:0] write_data,
    output logic [31:0] read_data,
    output logic        stall,
    output logic        misalign,
    output logic        bus_req,
    output logic        bus_we,
    output logic [31:0] bus_addr,
    output logic [31:0] bus_wdata,
`ifdef MEM_TIMEOUT_EN
    output logic        bus_err,
`endif
    input  logic [31:0] bus_rdata,
    input  logic        bus_ack
);

    if (TIMEOUT_CYCLES == 0 || TIMEOUT_CYCLES > 255) begin : g_bad_timeout
        $error("mem_access_ctrl: TIMEOUT_CYCLES must be in 1..255");
    end

    typedef enum logic [1:0] {
        IDLE,
        REQ,
        DONE
    } state_t;

    state_t      state_q, state_d;
    logic [31:0] read_data_q, read_data_d;
    logic [31:0] bus_addr_q, bus_addr_d;
    logic [31:0] bus_wdata_q, bus_wdata_d;
    logic        bus_we_q, bus_we_d;
    logic        access;
    logic        aligned;

`ifdef MEM_TIMEOUT_EN
    localparam logic [7:0] TMO_LIMIT = 8'(TIMEOUT_CYCLES);
    logic [7:0] tmo_cnt_q, tmo_cnt_d;
    logic       bus_err_q, bus_err_d;
`endif

    assign access  = MemRead | MemWrite;
    assign aligned = (ALU_result[1:0] == 2'b00);

    always_comb begin
        state_d     = state_q;
        read_data_d = read_data_q;
        bus_addr_d  = bus_addr_q;
        bus_wdata_d = bus_wdata_q;
        bus_we_d    = bus_we_q;
        stall       = 1'b0;
        misalign    = 1'b0;
        bus_req     = 1'b0;
`ifdef MEM_TIMEOUT_EN
        tmo_cnt_d   = tmo_cnt_q;
        bus_err_d   = bus_err_q;
`endif
        unique case (state_q)
            IDLE: begin
                // Gated by reset so the combinational outputs honour their reset values.
                if (access && !reset) begin
                    if (aligned) begin
                        stall       = 1'b1;
                        bus_addr_d  = {ALU_result[31:2], 2'b00};
                        bus_wdata_d = write_data;
                        bus_we_d    = MemWrite;
                        state_d     = REQ;
`ifdef MEM_TIMEOUT_EN
                        tmo_cnt_d   = '0;
`endif
                    end else begin
                        misalign = 1'b1;
                    end
                end
            end
            REQ: begin
                stall   = 1'b1;
                bus_req = 1'b1;
                if (bus_ack) begin
                    if (!bus_we_q) begin
                        read_data_d = bus_rdata;
                    end
                    state_d = DONE;
                end
`ifdef MEM_TIMEOUT_EN
                // An ack in the final allowed cycle wins over the timeout.
                else if (tmo_cnt_q + 8'd1 == TMO_LIMIT) begin
                    if (!bus_we_q) begin
                        read_data_d = 32'hDEAD_BEEF;
                    end
                    bus_err_d = 1'b1;
                    tmo_cnt_d = tmo_cnt_q + 8'd1;
                    state_d   = DONE;
                end else begin
                    tmo_cnt_d = tmo_cnt_q + 8'd1;
                end
`endif
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q     <= IDLE;
            read_data_q <= '0;
            bus_addr_q  <= '0;
            bus_wdata_q <= '0;
            bus_we_q    <= 1'b0;
`ifdef MEM_TIMEOUT_EN
            tmo_cnt_q   <= '0;
            bus_err_q   <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            read_data_q <= read_data_d;
            bus_addr_q  <= bus_addr_d;
            bus_wdata_q <= bus_wdata_d;
            bus_we_q    <= bus_we_d;
`ifdef MEM_TIMEOUT_EN
            tmo_cnt_q   <= tmo_cnt_d;
            bus_err_q   <= bus_err_d;
`endif
        end
    end

    assign read_data = read_data_q;
    assign bus_addr  = bus_addr_q;
    assign bus_wdata = bus_wdata_q;
    assign bus_we    = bus_we_q;
`ifdef MEM_TIMEOUT_EN
    assign bus_err   = bus_err_q;
`endif

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Self-checking bench for mem_access_ctrl; transaction-level expectations, random traffic.
// Define MEM_TIMEOUT_EN to also exercise the bus-wait timeout (TIMEOUT_CYCLES = 4).
module tb_mem_access_ctrl;

    localparam int TMO = 4;
`ifdef MEM_TIMEOUT_EN
    localparam int MAX_ACK = TMO;
`else
    localparam int MAX_ACK = 12;
`endif

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic        MemRead = 1'b0;
    logic        MemWrite = 1'b0;
    logic [31:0] ALU_result = '0;
    logic [31:0] write_data = '0;
    logic [31:0] read_data;
    logic        stall;
    logic        misalign;
    logic        bus_req;
    logic        bus_we;
    logic [31:0] bus_addr;
    logic [31:0] bus_wdata;
    logic [31:0] bus_rdata = '0;
    logic        bus_ack = 1'b0;
`ifdef MEM_TIMEOUT_EN
    logic        bus_err;
`endif

    mem_access_ctrl #(.TIMEOUT_CYCLES(TMO)) dut (
        .clock      (clock),
        .reset      (reset),
        .MemRead    (MemRead),
        .MemWrite   (MemWrite),
        .ALU_result (ALU_result),
        .write_data (write_data),
        .read_data  (read_data),
        .stall      (stall),
        .misalign   (misalign),
        .bus_req    (bus_req),
        .bus_we     (bus_we),
        .bus_addr   (bus_addr),
        .bus_wdata  (bus_wdata),
`ifdef MEM_TIMEOUT_EN
        .bus_err    (bus_err),
`endif
        .bus_rdata  (bus_rdata),
        .bus_ack    (bus_ack)
    );

    always #5 clock = ~clock;

    int passed = 0;
    int total  = 0;
    logic [31:0] model_rdata = '0;

    logic        obs_stall [64];
    logic        obs_req   [64];
    logic        obs_mis   [64];
    logic        obs_we    [64];
    logic [31:0] obs_rd    [64];
    logic [31:0] obs_addr  [64];
    logic [31:0] obs_wd    [64];

    // Drives one access (request held through cycle req_last), acks in cycle ack_at,
    // and records outputs per cycle. Called and returns at posedge+1.
    task automatic run_txn(input logic rd, input logic wr, input logic [31:0] addr,
                           input logic [31:0] wdata, input logic [31:0] rdata,
                           input int ack_at, input int req_last, input int ncyc);
        for (int c = 0; c < ncyc; c++) begin
            MemRead    = rd && (c <= req_last);
            MemWrite   = wr && (c <= req_last);
            ALU_result = (c <= req_last) ? addr : $urandom();
            write_data = (c <= req_last) ? wdata : $urandom();
            bus_ack    = (c == ack_at);
            bus_rdata  = (c == ack_at) ? rdata : $urandom();
            @(negedge clock);
            obs_stall[c] = stall;
            obs_req[c]   = bus_req;
            obs_mis[c]   = misalign;
            obs_we[c]    = bus_we;
            obs_rd[c]    = read_data;
            obs_addr[c]  = bus_addr;
            obs_wd[c]    = bus_wdata;
            @(posedge clock);
            #1;
        end
        MemRead  = 1'b0;
        MemWrite = 1'b0;
        bus_ack  = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (2) @(posedge clock);
        @(negedge clock);
        total++;
        if ({read_data, bus_addr, bus_wdata, bus_req, bus_we, stall, misalign} !== '0) begin
            $display("FAIL reset_values: rd=%h addr=%h wd=%h req=%b we=%b stall=%b mis=%b expected all 0",
                     read_data, bus_addr, bus_wdata, bus_req, bus_we, stall, misalign);
        end else passed++;
`ifdef MEM_TIMEOUT_EN
        total++;
        if (bus_err !== 1'b0) $display("FAIL reset_bus_err: got %b expected 0", bus_err);
        else passed++;
`endif
        @(posedge clock);
        #1;
        reset = 1'b0;
        model_rdata = '0;
    endtask

    task automatic test_load();
        int n_stall = 0;
        run_txn(1'b1, 1'b0, 32'h10, 32'h0, 32'h1234_5678, 3, 3, 6);
        for (int c = 0; c < 6; c++) n_stall += int'(obs_stall[c]);
        total++;
        if (obs_addr[1] !== 32'h10) $display("FAIL load_addr: got %h expected 00000010", obs_addr[1]);
        else passed++;
        total++;
        if (obs_we[1] !== 1'b0) $display("FAIL load_we: got %b expected 0", obs_we[1]);
        else passed++;
        total++;
        if (n_stall != 4) $display("FAIL load_stall_cycles: got %0d expected 4", n_stall);
        else passed++;
        total++;
        if (obs_rd[4] !== 32'h1234_5678) $display("FAIL load_data_done: got %h expected 12345678", obs_rd[4]);
        else passed++;
        total++;
        if (obs_req[4] !== 1'b0 || obs_stall[4] !== 1'b0)
            $display("FAIL load_done_outputs: req=%b stall=%b expected 0 0", obs_req[4], obs_stall[4]);
        else passed++;
        model_rdata = 32'h1234_5678;
    endtask

    task automatic test_store();
        run_txn(1'b0, 1'b1, 32'h24, 32'hA5A5_A5A5, 32'h0BAD_0BAD, 1, 1, 4);
        total++;
        if (obs_we[1] !== 1'b1 || obs_wd[1] !== 32'hA5A5_A5A5 || obs_req[1] !== 1'b1)
            $display("FAIL store_bus: we=%b wdata=%h req=%b expected 1 a5a5a5a5 1", obs_we[1], obs_wd[1], obs_req[1]);
        else passed++;
        total++;
        if (obs_rd[2] !== model_rdata || obs_rd[3] !== model_rdata)
            $display("FAIL store_read_data: got %h/%h expected %h", obs_rd[2], obs_rd[3], model_rdata);
        else passed++;
        total++;
        if (obs_stall[2] !== 1'b0 || obs_req[2] !== 1'b0 || obs_req[3] !== 1'b0)
            $display("FAIL store_return_idle: stall=%b req=%b/%b expected 0 0/0", obs_stall[2], obs_req[2], obs_req[3]);
        else passed++;
    endtask

    task automatic test_both();
        run_txn(1'b1, 1'b1, 32'h8, 32'h5555_AAAA, 32'h7777_7777, 2, 2, 5);
        total++;
        if (obs_we[1] !== 1'b1 || obs_addr[1] !== 32'h8 || obs_wd[2] !== 32'h5555_AAAA)
            $display("FAIL both_is_write: we=%b addr=%h wd=%h expected 1 00000008 5555aaaa", obs_we[1], obs_addr[1], obs_wd[2]);
        else passed++;
        total++;
        if (obs_rd[3] !== model_rdata) $display("FAIL both_read_data: got %h expected %h", obs_rd[3], model_rdata);
        else passed++;
    endtask

    task automatic test_misalign();
        run_txn(1'b1, 1'b0, 32'h13, 32'h0, 32'h0, -1, 0, 2);
        total++;
        if (obs_mis[0] !== 1'b1 || obs_stall[0] !== 1'b0 || obs_req[0] !== 1'b0)
            $display("FAIL misalign_pulse: mis=%b stall=%b req=%b expected 1 0 0", obs_mis[0], obs_stall[0], obs_req[0]);
        else passed++;
        total++;
        if (obs_mis[1] !== 1'b0 || obs_req[1] !== 1'b0 || obs_rd[1] !== model_rdata)
            $display("FAIL misalign_after: mis=%b req=%b rd=%h expected 0 0 %h", obs_mis[1], obs_req[1], obs_rd[1], model_rdata);
        else passed++;
    endtask

    task automatic test_stray_ack();
        run_txn(1'b0, 1'b0, 32'h0, 32'h0, 32'hFFFF_0000, 0, -1, 2);
        total++;
        if (obs_req[1] !== 1'b0 || obs_stall[1] !== 1'b0 || obs_rd[1] !== model_rdata)
            $display("FAIL idle_ack_ignored: req=%b stall=%b rd=%h expected 0 0 %h", obs_req[1], obs_stall[1], obs_rd[1], model_rdata);
        else passed++;
    endtask

    task automatic test_reset_mid();
        run_txn(1'b1, 1'b0, 32'h40, 32'h0, 32'h0, -1, 0, 2);
        reset = 1'b1;
        @(posedge clock);
        #1;
        reset = 1'b0;
        model_rdata = '0;
        run_txn(1'b0, 1'b0, 32'h0, 32'h0, 32'hCAFE_F00D, 0, -1, 3);
        total++;
        if (obs_req[0] !== 1'b0 || obs_stall[0] !== 1'b0 || obs_rd[0] !== 32'h0)
            $display("FAIL reset_mid_req: req=%b stall=%b rd=%h expected 0 0 00000000", obs_req[0], obs_stall[0], obs_rd[0]);
        else passed++;
        total++;
        if (obs_req[2] !== 1'b0 || obs_rd[2] !== 32'h0)
            $display("FAIL reset_late_ack: req=%b rd=%h expected 0 00000000", obs_req[2], obs_rd[2]);
        else passed++;
    endtask

    task automatic test_random();
        for (int t = 0; t < 24; t++) begin
            int          kind  = int'($urandom_range(0, 3));
            int          ack   = int'($urandom_range(1, MAX_ACK));
            int          hold  = int'($urandom_range(0, 1));
            logic [31:0] addr  = $urandom();
            logic [31:0] wdata = $urandom();
            logic [31:0] rdata = $urandom();
            logic        rd    = (kind != 1);
            logic        wr    = (kind == 1) || (kind == 2);
            logic [31:0] prev  = model_rdata;
            if (kind == 3) begin
                addr[1:0] = 2'($urandom_range(1, 3));
                run_txn(1'b1, 1'b0, addr, wdata, rdata, -1, 0, 2);
                total++;
                if (obs_mis[0] !== 1'b1 || obs_stall[0] !== 1'b0 || obs_req[1] !== 1'b0 || obs_rd[1] !== prev)
                    $display("FAIL rand_misalign[%0d]: mis=%b stall=%b req=%b rd=%h expected 1 0 0 %h",
                             t, obs_mis[0], obs_stall[0], obs_req[1], obs_rd[1], prev);
                else passed++;
                continue;
            end
            addr[1:0] = 2'b00;
            run_txn(rd, wr, addr, wdata, rdata, ack, ack + hold, ack + 3);
            if (rd && !wr) model_rdata = rdata;
            for (int c = 0; c < ack + 3; c++) begin
                logic        e_stall = (c <= ack);
                logic        e_req   = (c >= 1) && (c <= ack);
                logic [31:0] e_rd    = (c <= ack) ? prev : model_rdata;
                total++;
                if (obs_stall[c] !== e_stall || obs_req[c] !== e_req || obs_mis[c] !== 1'b0 || obs_rd[c] !== e_rd)
                    $display("FAIL rand_cycle[%0d.%0d]: stall=%b req=%b mis=%b rd=%h expected %b %b 0 %h",
                             t, c, obs_stall[c], obs_req[c], obs_mis[c], obs_rd[c], e_stall, e_req, e_rd);
                else passed++;
                if (e_req) begin
                    total++;
                    if (obs_addr[c] !== addr || obs_we[c] !== wr || obs_wd[c] !== wdata)
                        $display("FAIL rand_bus[%0d.%0d]: addr=%h we=%b wd=%h expected %h %b %h",
                                 t, c, obs_addr[c], obs_we[c], obs_wd[c], addr, wr, wdata);
                    else passed++;
                end
            end
        end
    endtask

`ifdef MEM_TIMEOUT_EN
    task automatic test_timeout();
        run_txn(1'b1, 1'b0, 32'h100, 32'h0, 32'h0, -1, 0, TMO + 3);
        total++;
        if (obs_req[TMO] !== 1'b1 || obs_req[TMO + 1] !== 1'b0 || obs_stall[TMO + 1] !== 1'b0)
            $display("FAIL timeout_done: req=%b/%b stall=%b expected 1/0 0", obs_req[TMO], obs_req[TMO + 1], obs_stall[TMO + 1]);
        else passed++;
        total++;
        if (obs_rd[TMO + 1] !== 32'hDEAD_BEEF) $display("FAIL timeout_data: got %h expected deadbeef", obs_rd[TMO + 1]);
        else passed++;
        model_rdata = 32'hDEAD_BEEF;
        run_txn(1'b1, 1'b0, 32'h104, 32'h0, 32'h1111_2222, 1, 1, 4);
        total++;
        if (bus_err !== 1'b1) $display("FAIL timeout_err_sticky: got %b expected 1", bus_err);
        else passed++;
        reset = 1'b1;
        @(posedge clock);
        #1;
        reset = 1'b0;
        model_rdata = '0;
        @(negedge clock);
        total++;
        if (bus_err !== 1'b0) $display("FAIL timeout_err_clear: got %b expected 0", bus_err);
        else passed++;
        @(posedge clock);
        #1;
    endtask
`endif

    initial begin
        @(posedge clock);
        #1;
        test_reset();
        test_load();
        test_store();
        test_both();
        test_misalign();
        test_stray_ack();
        test_reset_mid();
`ifdef MEM_TIMEOUT_EN
        test_timeout();
`endif
        test_random();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
